// File: rtl/watch_set_ctrl.sv
// ----------------------------------------------------------------------------
// watch_set_ctrl
// Mode/setting controller for the HH:MM:SS.cc watch datapath. Steps through
// RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN on btn_mode presses, issues
// single-cycle increment pulses (with press-and-hold auto-repeat) for the
// field being edited, freezes datapath counting while setting, blinks the
// edited field and falls back to RUN after an idle timeout.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   btn_mode     debounced mode button level
//   btn_up       debounced increment button level
//   o_run_en     1 = datapath counts, 0 = counting frozen
//   o_inc_hour   one-cycle hour increment pulse
//   o_inc_min    one-cycle minute increment pulse
//   o_inc_sec    one-cycle second increment pulse
//   o_clr_msec   one-cycle centisecond clear on leaving SET_SEC
//   o_edit_sel   0 = none/RUN, 1 = hour, 2 = min, 3 = sec
//   o_blink      1 = edited field visible, 0 = blanked
// ----------------------------------------------------------------------------
module watch_set_ctrl #(
    parameter int unsigned TICK_DIV   = 100_000,
    parameter int unsigned HOLD_MS    = 500,
    parameter int unsigned REPEAT_MS  = 100,
    parameter int unsigned BLINK_MS   = 250,
    parameter int unsigned TIMEOUT_MS = 10_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       o_run_en,
    output logic       o_inc_hour,
    output logic       o_inc_min,
    output logic       o_inc_sec,
    output logic       o_clr_msec,
    output logic [1:0] o_edit_sel,
    output logic       o_blink
);

    localparam int unsigned PRE_W   = $clog2(TICK_DIV + 1);
    localparam int unsigned HOLD_W  = $clog2(HOLD_MS + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_MS + 1);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_MS + 1);

    // State encoding doubles as the o_edit_sel value.
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_HOUR = 2'd1;
    localparam logic [1:0] S_MIN  = 2'd2;
    localparam logic [1:0] S_SEC  = 2'd3;

    logic [PRE_W-1:0]   r_presc;
    logic               r_mode_prev;
    logic               r_up_prev;
    logic [1:0]         r_state;
    logic               r_up_arm;
    logic [HOLD_W-1:0]  r_hold;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic [TMO_W-1:0]   r_tmo;

    logic               w_ms_tick;
    logic               w_mode_edge;
    logic               w_up_edge;
    logic               w_in_set;
    logic               w_state_chg;
    logic [1:0]         w_state_nxt;
    logic               w_arm_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [BLINK_W-1:0] w_blink_cnt_nxt;
    logic               w_blink_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic               w_inc;
    logic               w_clr_nxt;

    assign w_ms_tick   = (r_presc == PRE_W'(TICK_DIV - 1));
    assign w_mode_edge = btn_mode & ~r_mode_prev;
    assign w_up_edge   = btn_up & ~r_up_prev;
    assign w_in_set    = (r_state != S_RUN);

    // Next-state, counter and output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_arm_nxt       = r_up_arm;
        w_hold_nxt      = r_hold;
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_nxt     = o_blink;
        w_tmo_nxt       = r_tmo;
        w_inc           = 1'b0;
        w_clr_nxt       = 1'b0;

        // Mode sequencing; timeout only possible while idle in a SET state.
        if (w_mode_edge) begin
            case (r_state)
                S_RUN:   w_state_nxt = S_HOUR;
                S_HOUR:  w_state_nxt = S_MIN;
                S_MIN:   w_state_nxt = S_SEC;
                default: w_state_nxt = S_RUN;
            endcase
        end else if (w_in_set && !w_up_edge && !btn_up && w_ms_tick &&
                     (r_tmo == TMO_W'(TIMEOUT_MS - 1))) begin
            w_state_nxt = S_RUN;
        end
        w_state_chg = (w_state_nxt != r_state);
        w_clr_nxt   = (r_state == S_SEC) && (w_state_nxt == S_RUN);

        // Increment / auto-repeat. Arming only happens on an up edge inside a
        // stable SET state, so any state change while held suppresses repeat
        // until the button is released and pressed again.
        if (w_state_chg || !w_in_set) begin
            w_hold_nxt = '0;
            w_arm_nxt  = 1'b0;
        end else if (w_up_edge) begin
            w_inc      = 1'b1;
            w_hold_nxt = '0;
            w_arm_nxt  = 1'b1;
        end else if (!btn_up) begin
            w_hold_nxt = '0;
            w_arm_nxt  = 1'b0;
        end else if (r_up_arm && w_ms_tick) begin
            if (r_hold == HOLD_W'(HOLD_MS - 1)) begin
                w_inc      = 1'b1;
                w_hold_nxt = HOLD_W'(HOLD_MS - REPEAT_MS);
            end else begin
                w_hold_nxt = r_hold + HOLD_W'(1);
            end
        end

        // Idle timeout counter.
        if (w_state_chg || !w_in_set || w_mode_edge || w_up_edge || btn_up) begin
            w_tmo_nxt = '0;
        end else if (w_ms_tick) begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
        end

        // Blink: restart visible on entry and on each increment.
        if (w_state_nxt == S_RUN || w_state_chg || w_inc) begin
            w_blink_nxt     = 1'b1;
            w_blink_cnt_nxt = '0;
        end else if (w_ms_tick) begin
            if (r_blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
                w_blink_nxt     = ~o_blink;
                w_blink_cnt_nxt = '0;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc     <= '0;
            r_mode_prev <= 1'b1;
            r_up_prev   <= 1'b1;
            r_state     <= S_RUN;
            r_up_arm    <= 1'b0;
            r_hold      <= '0;
            r_blink_cnt <= '0;
            r_tmo       <= '0;
            o_run_en    <= 1'b1;
            o_inc_hour  <= 1'b0;
            o_inc_min   <= 1'b0;
            o_inc_sec   <= 1'b0;
            o_clr_msec  <= 1'b0;
            o_edit_sel  <= S_RUN;
            o_blink     <= 1'b1;
        end else begin
            r_presc     <= w_ms_tick ? '0 : r_presc + PRE_W'(1);
            r_mode_prev <= btn_mode;
            r_up_prev   <= btn_up;
            r_state     <= w_state_nxt;
            r_up_arm    <= w_arm_nxt;
            r_hold      <= w_hold_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_tmo       <= w_tmo_nxt;
            o_run_en    <= (w_state_nxt == S_RUN);
            o_inc_hour  <= w_inc && (r_state == S_HOUR);
            o_inc_min   <= w_inc && (r_state == S_MIN);
            o_inc_sec   <= w_inc && (r_state == S_SEC);
            o_clr_msec  <= w_clr_nxt;
            o_edit_sel  <= w_state_nxt;
            o_blink     <= w_blink_nxt;
        end
    end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// ----------------------------------------------------------------------------
// tb_watch_set_ctrl
// Directed self-checking bench for watch_set_ctrl with small timing
// parameters (4 clk per ms tick). Inputs change and outputs are sampled 1 time
// unit after the falling clock edge.
// ----------------------------------------------------------------------------
module tb_watch_set_ctrl;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned HOLD_MS    = 5;
    localparam int unsigned REPEAT_MS  = 2;
    localparam int unsigned BLINK_MS   = 3;
    localparam int unsigned TIMEOUT_MS = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_up;
    logic       o_run_en;
    logic       o_inc_hour;
    logic       o_inc_min;
    logic       o_inc_sec;
    logic       o_clr_msec;
    logic [1:0] o_edit_sel;
    logic       o_blink;

    int errors = 0;
    int checks = 0;
    int ph     = 0;
    int n_hour = 0;
    int n_min  = 0;
    int n_sec  = 0;
    int n_clr  = 0;
    int n_multi = 0;
    int h0, m0, s0, c0;

    watch_set_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .HOLD_MS    (HOLD_MS),
        .REPEAT_MS  (REPEAT_MS),
        .BLINK_MS   (BLINK_MS),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .o_run_en   (o_run_en),
        .o_inc_hour (o_inc_hour),
        .o_inc_min  (o_inc_min),
        .o_inc_sec  (o_inc_sec),
        .o_clr_msec (o_clr_msec),
        .o_edit_sel (o_edit_sel),
        .o_blink    (o_blink)
    );

    always #5 clk = ~clk;

    // Free-running ms prescaler phase: value the prescaler holds right now.
    always @(posedge clk or posedge reset) begin
        if (reset) ph <= 0;
        else       ph <= (ph == int'(TICK_DIV) - 1) ? 0 : ph + 1;
    end

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (o_inc_hour === 1'b1) n_hour = n_hour + 1;
        if (o_inc_min  === 1'b1) n_min  = n_min + 1;
        if (o_inc_sec  === 1'b1) n_sec  = n_sec + 1;
        if (o_clr_msec === 1'b1) n_clr  = n_clr + 1;
        if ((int'(o_inc_hour) + int'(o_inc_min) + int'(o_inc_sec)) > 1)
            n_multi = n_multi + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Stop where the prescaler is at 0, so the next rising edge is not a tick.
    task automatic wait_ph0();
        for (int g = 0; g < 8 && ph != 0; g++) step(1);
    endtask

    task automatic snap();
        h0 = n_hour; m0 = n_min; s0 = n_sec; c0 = n_clr;
    endtask

    task automatic tap_mode(input logic [1:0] exp_sel);
        btn_mode = 1'b1;
        step(1);
        chk("tap_sel", 32'(o_edit_sel), 32'(exp_sel));
        chk("tap_run_en", 32'(o_run_en), 32'(exp_sel == 2'd0));
        btn_mode = 1'b0;
        step(1);
    endtask

    initial begin
        int tk;
        // ---- reset, with btn_mode held through release ----
        reset = 1'b1; btn_mode = 1'b1; btn_up = 1'b0;
        #1;
        chk("rst_sel", 32'(o_edit_sel), 32'd0);
        chk("rst_run_en", 32'(o_run_en), 32'd1);
        chk("rst_blink", 32'(o_blink), 32'd1);
        chk("rst_clr", 32'(o_clr_msec), 32'd0);
        chk("rst_inc", 32'(o_inc_hour | o_inc_min | o_inc_sec), 32'd0);
        step(3);
        reset = 1'b0;
        step(5);
        chk("held_mode_sel", 32'(o_edit_sel), 32'd0);
        chk("held_mode_run", 32'(o_run_en), 32'd1);

        // ---- four mode taps ----
        btn_mode = 1'b0;
        step(2);
        snap();
        tap_mode(2'd1);
        tap_mode(2'd2);
        tap_mode(2'd3);
        chk("clr_before_exit", 32'(n_clr - c0), 32'd0);
        btn_mode = 1'b1;
        step(1);
        chk("exit_sel", 32'(o_edit_sel), 32'd0);
        chk("exit_run_en", 32'(o_run_en), 32'd1);
        chk("exit_clr", 32'(o_clr_msec), 32'd1);
        btn_mode = 1'b0;
        step(1);
        chk("exit_clr_end", 32'(o_clr_msec), 32'd0);
        chk("exit_clr_count", 32'(n_clr - c0), 32'd1);

        // ---- SET_MIN single up tap ----
        tap_mode(2'd1);
        tap_mode(2'd2);
        snap();
        btn_up = 1'b1;
        step(1);
        chk("tap_inc_min", 32'(o_inc_min), 32'd1);
        chk("tap_inc_hour", 32'(o_inc_hour), 32'd0);
        chk("tap_inc_sec", 32'(o_inc_sec), 32'd0);
        chk("tap_blink", 32'(o_blink), 32'd1);
        step(1);
        chk("tap_inc_min_off", 32'(o_inc_min), 32'd0);
        step(1);
        btn_up = 1'b0;
        step(3);
        chk("tap_min_cnt", 32'(n_min - m0), 32'd1);
        chk("tap_other_cnt", 32'(n_hour - h0 + n_sec - s0), 32'd0);
        tap_mode(2'd3);
        tap_mode(2'd0);

        // ---- SET_HOUR hold with auto-repeat ----
        tap_mode(2'd1);
        wait_ph0();
        snap();
        btn_up = 1'b1;
        for (int k = 0; k <= 44; k++) begin
            step(1);
            // edge pulse, then ticks 5,7,9,11 land on rising edges E+19/27/35/43
            chk("hold_pulse", 32'(o_inc_hour),
                32'(k == 0 || k == 19 || k == 27 || k == 35 || k == 43));
        end
        btn_up = 1'b0;
        step(2);
        chk("hold_hour_cnt", 32'(n_hour - h0), 32'd5);
        chk("hold_other_cnt", 32'(n_min - m0 + n_sec - s0), 32'd0);
        chk("hold_sel", 32'(o_edit_sel), 32'd1);
        tap_mode(2'd2);
        tap_mode(2'd3);
        tap_mode(2'd0);

        // ---- SET_SEC idle timeout with blinking ----
        tap_mode(2'd1);
        tap_mode(2'd2);
        wait_ph0();
        snap();
        btn_mode = 1'b1;
        for (int k = 0; k <= 80; k++) begin
            step(1);
            if (k == 0) btn_mode = 1'b0;
            tk = (k + 1) / 4;
            chk("tmo_sel", 32'(o_edit_sel), (tk >= 20) ? 32'd0 : 32'd3);
            chk("tmo_blink", 32'(o_blink),
                (tk >= 20) ? 32'd1 : 32'(((tk / 3) % 2) == 0));
            chk("tmo_clr", 32'(o_clr_msec), 32'(k == 79));
        end
        chk("tmo_clr_cnt", 32'(n_clr - c0), 32'd1);
        chk("tmo_run_en", 32'(o_run_en), 32'd1);

        // ---- SET_HOUR: mode and up edges together ----
        tap_mode(2'd1);
        snap();
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        step(1);
        chk("both_sel", 32'(o_edit_sel), 32'd2);
        chk("both_inc", 32'(o_inc_hour | o_inc_min | o_inc_sec), 32'd0);
        btn_mode = 1'b0;
        step(40);
        chk("both_no_pulse", 32'(n_hour - h0 + n_min - m0 + n_sec - s0), 32'd0);
        chk("both_sel_kept", 32'(o_edit_sel), 32'd2);
        btn_up = 1'b0;
        step(2);
        btn_up = 1'b1;
        step(1);
        chk("repress_inc_min", 32'(o_inc_min), 32'd1);
        btn_up = 1'b0;
        step(2);
        tap_mode(2'd3);
        tap_mode(2'd0);

        // ---- reset mid-operation with btn_up held ----
        tap_mode(2'd1);
        tap_mode(2'd2);
        btn_up = 1'b1;
        step(1);
        chk("pre_rst_inc", 32'(o_inc_min), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_inc", 32'(o_inc_min), 32'd0);
        chk("async_sel", 32'(o_edit_sel), 32'd0);
        chk("async_run_en", 32'(o_run_en), 32'd1);
        chk("async_blink", 32'(o_blink), 32'd1);
        step(2);
        reset = 1'b0;
        snap();
        step(40);
        chk("post_rst_pulse", 32'(n_hour - h0 + n_min - m0 + n_sec - s0), 32'd0);
        chk("post_rst_sel", 32'(o_edit_sel), 32'd0);
        tap_mode(2'd1);
        step(30);
        chk("enter_held_pulse", 32'(n_hour - h0), 32'd0);
        btn_up = 1'b0;
        step(2);
        tap_mode(2'd2);
        tap_mode(2'd3);
        tap_mode(2'd0);

        chk("one_hot_inc", 32'(n_multi), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Mode/setting controller for the HH:MM:SS.cc watch datapath; sits between the debounced user buttons and the datapath's per-field increment inputs.
- Sequences RUN → SET_HOUR → SET_MIN → SET_SEC → RUN.
- Generates single-cycle increment pulses for the selected field, with press-and-hold auto-repeat.
- Gates datapath counting while setting, provides a blink strobe for the edited field, and returns to RUN after an idle timeout.

Parameters:
- TICK_DIV, 100_000: clk cycles per internal 1 ms tick (100 MHz clk).
- HOLD_MS, 500: ms btn_up must be held before the first auto-repeat pulse.
- REPEAT_MS, 100: ms between auto-repeat pulses after the first.
- BLINK_MS, 250: o_blink half-period in ms.
- TIMEOUT_MS, 10_000: ms of no button edge in a SET state before forced return to RUN.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- btn_mode  input  1  debounced level, mode button.
- btn_up  input  1  debounced level, increment button.
- o_run_en  output  1  1 = datapath counts; 0 = counting frozen.
- o_inc_hour  output  1  one-cycle hour increment pulse.
- o_inc_min  output  1  one-cycle minute increment pulse.
- o_inc_sec  output  1  one-cycle second increment pulse.
- o_clr_msec  output  1  one-cycle pulse clearing centiseconds on leaving SET_SEC.
- o_edit_sel  output  2  0 = none/RUN, 1 = hour, 2 = min, 3 = sec.
- o_blink  output  1  1 = edited field visible, 0 = blanked.

Behaviour:
- Clock and reset: clk, reset asynchronous active-high. All outputs registered.
- Reset values:
  - State RUN; o_run_en = 1; o_inc_* = 0; o_clr_msec = 0; o_edit_sel = 0; o_blink = 1.
  - Prescaler, hold, blink and timeout counters = 0.
  - Edge-detect history regs = 1, so a button held through reset release produces no edge.
- Reset mid-operation: all outputs take reset values immediately (asynchronous); no pending pulse survives.
- ms tick: free-running prescaler 0..TICK_DIV-1; ms_tick is high for one cycle at wrap. Not restarted by buttons.
- Edges: rising edge = (btn=1 && prev=0), sampled at cycle N. All responses appear at N+1.
- FSM:
  - btn_mode edge: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
  - In SET states, o_run_en = 0 and o_edit_sel = 1/2/3. In RUN, o_run_en = 1 and o_edit_sel = 0.
- o_clr_msec: exactly one pulse on every SET_SEC→RUN transition, whether by mode edge or timeout; coincides with o_run_en returning to 1.
- btn_up in a SET state:
  - Edge → one pulse on the o_inc_* matching the state; hold counter cleared.
  - While held, hold counter increments on each ms_tick.
  - When it reaches HOLD_MS: pulse, then reload to HOLD_MS-REPEAT_MS (repeat every REPEAT_MS).
  - Release clears the hold counter.
- btn_up in RUN: ignored; no pulses; hold counter held at 0.
- Simultaneous btn_mode and btn_up edges: mode wins, no inc pulse. Auto-repeat is suppressed until btn_up is released and pressed again; this applies to any state change while btn_up is held.
- At most one o_inc_* is high in any cycle.
- Blink:
  - In SET states, o_blink toggles every BLINK_MS ms_ticks.
  - The blink counter is reset, and o_blink forced to 1, on entering any SET state and on every inc pulse.
  - In RUN, o_blink = 1.
- Timeout:
  - Counter clears on any btn_mode/btn_up edge, on state entry, and while btn_up is held.
  - Otherwise it increments on ms_tick in SET states.
  - On reaching TIMEOUT_MS, next state is RUN.
- Width rule: each counter is $clog2(param+1) bits; no overflow is possible by construction.

Test Plan:
All scenarios use TICK_DIV=4, HOLD_MS=5, REPEAT_MS=2, BLINK_MS=3, TIMEOUT_MS=20.
- Reset release with btn_mode held high → no state change; then 4 mode taps → o_edit_sel 1,2,3,0; o_run_en 0,0,0,1; exactly one o_clr_msec pulse, on the 4th tap.
- SET_MIN, single btn_up tap (3 cycles) → o_inc_min high exactly 1 cycle, at edge+1; o_inc_hour = o_inc_sec = 0; o_blink = 1 that cycle.
- SET_HOUR, btn_up held 11 ms after edge → o_inc_hour pulses at edge+1, then at ms_ticks 5, 7, 9, 11 of the hold: 5 pulses total.
- SET_SEC, no buttons for 20 ms_ticks → RUN; o_clr_msec 1 pulse; o_run_en = 1; o_edit_sel = 0; o_blink toggled at ticks 3, 6, 9, ... before exit.
- SET_HOUR, btn_mode and btn_up rising in the same cycle, btn_up held 10 ms → state SET_MIN; zero o_inc_* pulses.
- SET_MIN with btn_up held, reset asserted for 2 cycles → outputs reset asynchronously; after release with btn_up still high, no o_inc_* pulse for 10 ms.
